// File: rtl/rx_sweep_ctrl_if.sv
// Result channel of the receive sweep controller: one averaged point per
// valid/ready handshake.
interface rx_sweep_ctrl_if #(
  parameter int MW  = 16,
  parameter int PHW = 25
);
  logic           res_valid;
  logic           res_ready;
  logic [11:0]    res_index;
  logic [MW-1:0]  res_mag;
  logic [PHW-1:0] res_phase;

  modport master (output res_valid, res_index, res_mag, res_phase, input res_ready);
  modport slave  (input res_valid, res_index, res_mag, res_phase, output res_ready);
endinterface

// File: rtl/rx_sweep_ctrl.sv
// Frequency sweep sequencer: steps the rx NCO increment, settles, averages
// 2^AVG_LOG2 magnitudes per point. RX_SWEEP_PEAK_TRACK_EN adds peak tracking.
module rx_sweep_ctrl #(
  parameter int PW       = 19,
  parameter int MW       = 16,
  parameter int PHW      = 25,
  parameter int AVG_LOG2 = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [PW-1:0]        f_start,
  input  logic [PW-1:0]        f_step,
  input  logic [11:0]          n_points,
  input  logic [7:0]           settle_samples,
  input  logic                 ce_down,
  input  logic [MW-1:0]        rx_magnitude,
  input  logic [PHW-1:0]       rx_phase,
  output logic [PW-1:0]        phase_inc,
  rx_sweep_ctrl_if.master      res,
`ifdef RX_SWEEP_PEAK_TRACK_EN
  output logic [MW-1:0]        peak_mag,
  output logic [11:0]          peak_index,
`endif
  output logic                 busy,
  output logic                 done
);

  localparam int AW = MW + AVG_LOG2;
  localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, ACQ, EMIT, FINISH} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_inc_q, phase_inc_d;
  logic [PW-1:0]     f_step_q, f_step_d;
  logic [11:0]       n_pts_q, n_pts_d;
  logic [7:0]        settle_q, settle_d;
  logic [11:0]       index_q, index_d;
  logic [7:0]        settle_cnt_q, settle_cnt_d;
  logic [AVG_LOG2:0] avg_cnt_q, avg_cnt_d;
  logic [AW-1:0]     acc_q, acc_d, acc_sum;
  logic              res_valid_q, res_valid_d;
  logic [11:0]       res_index_q, res_index_d;
  logic [MW-1:0]     res_mag_q, res_mag_d;
  logic [PHW-1:0]    res_phase_q, res_phase_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef RX_SWEEP_PEAK_TRACK_EN
  logic [MW-1:0]     peak_mag_q, peak_mag_d;
  logic [11:0]       peak_index_q, peak_index_d;
`endif

  always_comb begin
    state_d      = state_q;
    phase_inc_d  = phase_inc_q;
    f_step_d     = f_step_q;
    n_pts_d      = n_pts_q;
    settle_d     = settle_q;
    index_d      = index_q;
    settle_cnt_d = settle_cnt_q;
    avg_cnt_d    = avg_cnt_q;
    acc_d        = acc_q;
    res_valid_d  = res_valid_q;
    res_index_d  = res_index_q;
    res_mag_d    = res_mag_q;
    res_phase_d  = res_phase_q;
    done_d       = 1'b0;
`ifdef RX_SWEEP_PEAK_TRACK_EN
    peak_mag_d   = peak_mag_q;
    peak_index_d = peak_index_q;
`endif
    acc_sum = acc_q + AW'(rx_magnitude);

    // Abort beats any handshake or sample arriving in the same cycle.
    if (stop && state_q != IDLE) begin
      state_d      = IDLE;
      res_valid_d  = 1'b0;
      settle_cnt_d = '0;
      avg_cnt_d    = '0;
      acc_d        = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          f_step_d     = f_step;
          n_pts_d      = n_points;
          settle_d     = settle_samples;
          index_d      = '0;
          settle_cnt_d = '0;
          avg_cnt_d    = '0;
          acc_d        = '0;
`ifdef RX_SWEEP_PEAK_TRACK_EN
          peak_mag_d   = '0;
          peak_index_d = '0;
`endif
          if (n_points != 12'd0) begin
            phase_inc_d = f_start;
            state_d     = SETTLE;
          end else begin
            state_d     = FINISH;
          end
        end
        SETTLE: begin
          if (settle_q == 8'd0) begin
            state_d = ACQ;
          end else if (ce_down) begin
            if (settle_cnt_q == settle_q - 8'd1) begin
              settle_cnt_d = '0;
              state_d      = ACQ;
            end else begin
              settle_cnt_d = settle_cnt_q + 8'd1;
            end
          end
        end
        ACQ: if (ce_down) begin
          if (avg_cnt_q == AVG_LAST) begin
            res_mag_d   = acc_sum[AW-1:AVG_LOG2];
            res_phase_d = rx_phase;
            res_index_d = index_q;
            res_valid_d = 1'b1;
            acc_d       = '0;
            avg_cnt_d   = '0;
            state_d     = EMIT;
          end else begin
            acc_d     = acc_sum;
            avg_cnt_d = avg_cnt_q + 1'b1;
          end
        end
        EMIT: if (res.res_ready) begin
          res_valid_d = 1'b0;
`ifdef RX_SWEEP_PEAK_TRACK_EN
          if (res_mag_q > peak_mag_q) begin
            peak_mag_d   = res_mag_q;
            peak_index_d = res_index_q;
          end
`endif
          if (index_q == n_pts_q - 12'd1) begin
            state_d = FINISH;
          end else begin
            index_d     = index_q + 12'd1;
            phase_inc_d = phase_inc_q + f_step_q;
            state_d     = SETTLE;
          end
        end
        FINISH: begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      phase_inc_q  <= '0;
      f_step_q     <= '0;
      n_pts_q      <= '0;
      settle_q     <= '0;
      index_q      <= '0;
      settle_cnt_q <= '0;
      avg_cnt_q    <= '0;
      acc_q        <= '0;
      res_valid_q  <= 1'b0;
      res_index_q  <= '0;
      res_mag_q    <= '0;
      res_phase_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef RX_SWEEP_PEAK_TRACK_EN
      peak_mag_q   <= '0;
      peak_index_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phase_inc_q  <= phase_inc_d;
      f_step_q     <= f_step_d;
      n_pts_q      <= n_pts_d;
      settle_q     <= settle_d;
      index_q      <= index_d;
      settle_cnt_q <= settle_cnt_d;
      avg_cnt_q    <= avg_cnt_d;
      acc_q        <= acc_d;
      res_valid_q  <= res_valid_d;
      res_index_q  <= res_index_d;
      res_mag_q    <= res_mag_d;
      res_phase_q  <= res_phase_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef RX_SWEEP_PEAK_TRACK_EN
      peak_mag_q   <= peak_mag_d;
      peak_index_q <= peak_index_d;
`endif
    end
  end

  assign phase_inc     = phase_inc_q;
  assign res.res_valid = res_valid_q;
  assign res.res_index = res_index_q;
  assign res.res_mag   = res_mag_q;
  assign res.res_phase = res_phase_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef RX_SWEEP_PEAK_TRACK_EN
  assign peak_mag      = peak_mag_q;
  assign peak_index    = peak_index_q;
`endif

endmodule

// File: tb/tb_rx_sweep_ctrl.sv
// Directed bench for rx_sweep_ctrl: table of whole sweeps plus hand-written
// abort, reset, empty-sweep and (optionally) peak-tracking sequences.
module tb_rx_sweep_ctrl;
  localparam int PW = 19, MW = 16, PHW = 25, AVG_LOG2 = 4;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b0, start = 1'b0, stop = 1'b0, ce_down = 1'b0;
  logic [PW-1:0]  f_start = '0, f_step = '0;
  logic [11:0]    n_points = '0;
  logic [7:0]     settle_samples = '0;
  logic [MW-1:0]  rx_magnitude = '0;
  logic [PHW-1:0] rx_phase = '0;
  logic [PW-1:0]  phase_inc;
  logic           busy, done;
`ifdef RX_SWEEP_PEAK_TRACK_EN
  logic [MW-1:0]  peak_mag;
  logic [11:0]    peak_index;
`endif

  rx_sweep_ctrl_if #(.MW(MW), .PHW(PHW)) res_if ();

  rx_sweep_ctrl #(.PW(PW), .MW(MW), .PHW(PHW), .AVG_LOG2(AVG_LOG2)) dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .stop(stop),
    .f_start(f_start), .f_step(f_step), .n_points(n_points),
    .settle_samples(settle_samples), .ce_down(ce_down),
    .rx_magnitude(rx_magnitude), .rx_phase(rx_phase),
    .phase_inc(phase_inc), .res(res_if),
`ifdef RX_SWEEP_PEAK_TRACK_EN
    .peak_mag(peak_mag), .peak_index(peak_index),
`endif
    .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  typedef struct {
    logic [PW-1:0] fs;
    logic [PW-1:0] fst;
    logic [11:0]   n;
    logic [7:0]    st;
    logic [MW-1:0] base;
    logic [MW-1:0] inc;
    int            stall;
    logic [MW-1:0] exp_mag;
    logic [PW-1:0] exp_last;
  } vec_t;

  vec_t tbl[5];

  // Drives settle pulses (garbage data) then one full averaging window of
  // base + i*inc; leaves the DUT in EMIT after the last pulse.
  task automatic feed_point(input logic [7:0] st, input logic [MW-1:0] base,
                            input logic [MW-1:0] inc, input logic [PHW-1:0] ph);
    for (int s = 0; s < int'(st); s++) begin
      ce_down = 1'b1; rx_magnitude = 16'hDEAD; tick();
      ce_down = 1'b0; tick();
    end
    for (int i = 0; i < 16; i++) begin
      ce_down = 1'b1;
      rx_magnitude = base + MW'(i) * inc;
      rx_phase = ph + PHW'(i);
      tick();
      ce_down = 1'b0;
      if (i < 15) begin
        tick();
        if (i == 14) chk("valid_before_window_end", res_if.res_valid, 1'b0);
      end
    end
  endtask

  task automatic run_row(input vec_t v);
    logic [PW-1:0] pinc;
    f_start = v.fs; f_step = v.fst; n_points = v.n; settle_samples = v.st;
    start = 1'b1; tick();
    chk("start_busy", busy, 1'b1);
    chk("start_phase_inc", phase_inc, v.fs);
    chk("start_no_valid", res_if.res_valid, 1'b0);
    // Changed inputs plus a repeated start must not disturb the running sweep.
    f_start = ~v.fs; f_step = ~v.fst; n_points = 12'd7; settle_samples = 8'd9;
    tick();
    start = 1'b0;
    chk("latched_phase_inc", phase_inc, v.fs);
    pinc = v.fs;
    for (int k = 0; k < int'(v.n); k++) begin
      if (k > 0) tick();
      feed_point(v.st, v.base, v.inc, PHW'(k * 100));
      chk("res_valid", res_if.res_valid, 1'b1);
      chk("res_index", res_if.res_index, 12'(k));
      chk("res_mag", res_if.res_mag, v.exp_mag);
      chk("res_phase", res_if.res_phase, PHW'(k * 100 + 15));
      chk("point_phase_inc", phase_inc, pinc);
      for (int c = 0; c < v.stall; c++) begin
        ce_down = (c % 2 == 0); rx_magnitude = 16'hBEEF; rx_phase = 25'h1ABCDEF;
        tick();
        chk("stall_valid", res_if.res_valid, 1'b1);
        chk("stall_mag", res_if.res_mag, v.exp_mag);
        chk("stall_index", res_if.res_index, 12'(k));
      end
      ce_down = 1'b0;
      res_if.res_ready = 1'b1; tick(); res_if.res_ready = 1'b0;
      chk("handshake_valid_low", res_if.res_valid, 1'b0);
      if (k < int'(v.n) - 1) begin
        pinc = pinc + v.fst;
        chk("next_phase_inc", phase_inc, pinc);
      end else begin
        chk("finish_busy", busy, 1'b1);
        chk("finish_done_low", done, 1'b0);
      end
    end
    tick();
    chk("done_pulse", done, 1'b1);
    chk("done_busy_low", busy, 1'b0);
    chk("last_phase_inc", phase_inc, v.exp_last);
    tick();
    chk("done_single", done, 1'b0);
    chk("idle_phase_hold", phase_inc, v.exp_last);
  endtask

  initial begin
    tbl[0] = '{fs:19'd1000, fst:19'd250, n:12'd4, st:8'd3, base:16'h1234, inc:16'd0,
               stall:20, exp_mag:16'h1234, exp_last:19'd1750};
    tbl[1] = '{fs:19'd0, fst:19'd1, n:12'd1, st:8'd0, base:16'd0, inc:16'd1,
               stall:0, exp_mag:16'd7, exp_last:19'd0};
    tbl[2] = '{fs:19'h7FFFF, fst:19'd2, n:12'd2, st:8'd1, base:16'hFFFF, inc:16'd0,
               stall:0, exp_mag:16'hFFFF, exp_last:19'h00001};
    tbl[3] = '{fs:19'd5, fst:19'h10, n:12'd3, st:8'd2, base:16'd100, inc:16'd2,
               stall:3, exp_mag:16'd115, exp_last:19'h25};
    tbl[4] = '{fs:19'h4321, fst:19'd9, n:12'd1, st:8'd5, base:16'hFFF0, inc:16'd1,
               stall:0, exp_mag:16'hFFF7, exp_last:19'h4321};
    res_if.res_ready = 1'b0;

    // Reset dominates a concurrent start.
    start = 1'b1; f_start = 19'h55; n_points = 12'd3;
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_phase_inc", phase_inc, 19'd0);
    chk("rst_valid", res_if.res_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mag", res_if.res_mag, 16'd0);
    start = 1'b0; rst = 1'b1; tick();

    for (int r = 0; r < 5; r++) run_row(tbl[r]);

    // Abort during the second point's settle window.
    f_start = 19'd10; f_step = 19'd5; n_points = 12'd3; settle_samples = 8'd4;
    start = 1'b1; tick(); start = 1'b0; tick();
    feed_point(8'd4, 16'h50, 16'd0, 25'd0);
    chk("abort_p0_mag", res_if.res_mag, 16'h50);
    res_if.res_ready = 1'b1; tick(); res_if.res_ready = 1'b0;
    chk("abort_p1_phase_inc", phase_inc, 19'd15);
    tick();
    ce_down = 1'b1; tick(); ce_down = 1'b0; tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 1'b0);
    chk("stop_valid", res_if.res_valid, 1'b0);
    chk("stop_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin tick(); chk("stop_no_done", done, 1'b0); end

    // Start wins over stop in IDLE; stop wins over a handshake in EMIT.
    f_start = 19'd77; n_points = 12'd1; settle_samples = 8'd0;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_beats_stop", busy, 1'b1);
    chk("start_beats_stop_pinc", phase_inc, 19'd77);
    tick();
    feed_point(8'd0, 16'h40, 16'd0, 25'd0);
    chk("pre_stop_valid", res_if.res_valid, 1'b1);
    stop = 1'b1; res_if.res_ready = 1'b1; tick(); stop = 1'b0; res_if.res_ready = 1'b0;
    chk("stop_hs_valid", res_if.res_valid, 1'b0);
    chk("stop_hs_busy", busy, 1'b0);
    tick();
    chk("stop_hs_no_done", done, 1'b0);

    // Reset mid-acquisition of the second point.
    f_start = 19'h123; f_step = 19'd1; n_points = 12'd2; settle_samples = 8'd0;
    start = 1'b1; tick(); start = 1'b0; tick();
    feed_point(8'd0, 16'h77, 16'd0, 25'd0);
    res_if.res_ready = 1'b1; tick(); res_if.res_ready = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      ce_down = 1'b1; rx_magnitude = 16'h3000; tick(); ce_down = 1'b0; tick();
    end
    rst = 1'b0; tick();
    chk("midrst_phase_inc", phase_inc, 19'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", res_if.res_valid, 1'b0);
    chk("midrst_index", res_if.res_index, 12'd0);
    chk("midrst_mag", res_if.res_mag, 16'd0);
    chk("midrst_phase", res_if.res_phase, 25'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("midrst_no_done", done, 1'b0); end
    f_start = 19'd3; n_points = 12'd1;
    start = 1'b1; tick(); start = 1'b0; tick();
    feed_point(8'd0, 16'h10, 16'd0, 25'd0);
    chk("post_rst_acc_clear", res_if.res_mag, 16'h10);
    res_if.res_ready = 1'b1; tick(); res_if.res_ready = 1'b0; tick(); tick();

    // Empty sweep.
    n_points = 12'd0; f_start = 19'h55;
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", busy, 1'b1);
    chk("empty_no_done_yet", done, 1'b0);
    tick();
    chk("empty_done", done, 1'b1);
    chk("empty_busy_low", busy, 1'b0);
    chk("empty_no_valid", res_if.res_valid, 1'b0);
    tick();
    chk("empty_done_single", done, 1'b0);

`ifdef RX_SWEEP_PEAK_TRACK_EN
    begin
      logic [MW-1:0] mags[4];
      mags[0] = 16'd5; mags[1] = 16'd9; mags[2] = 16'd9; mags[3] = 16'd3;
      f_start = 19'd0; f_step = 19'd1; n_points = 12'd4; settle_samples = 8'd0;
      start = 1'b1; tick(); start = 1'b0;
      chk("peak_cleared", peak_mag, 16'd0);
      for (int k = 0; k < 4; k++) begin
        tick();
        feed_point(8'd0, mags[k], 16'd0, 25'd0);
        res_if.res_ready = 1'b1; tick(); res_if.res_ready = 1'b0;
      end
      tick();
      chk("peak_done", done, 1'b1);
      chk("peak_mag", peak_mag, 16'd9);
      chk("peak_index", peak_index, 12'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rx_sweep_ctrl.md
RX_SWEEP_CTRL -- requirements
Module: rx_sweep_ctrl

Interface
REQ-001 SHALL have parameter PW, default 19, phase-increment width (matches rx channel NCO).
REQ-002 SHALL have parameter MW, default 16, magnitude width.
REQ-003 SHALL have parameter PHW, default 25, polar phase width.
REQ-004 SHALL have parameter AVG_LOG2, default 4, log2 of magnitude samples averaged per point.
REQ-005 SHALL have port sys_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports start  in  1  sweep launch pulse; stop  in  1  abort pulse.
REQ-008 SHALL have ports f_start  in  PW  first increment; f_step  in  PW  per-point increment step.
REQ-009 SHALL have ports n_points  in  12  point count; settle_samples  in  8  decimated samples discarded per point.
REQ-010 SHALL have ports ce_down  in  1  decimated-sample strobe; rx_magnitude  in  MW  unsigned magnitude; rx_phase  in  PHW  polar phase.
REQ-011 SHALL have port phase_inc  out  PW  drives rx channel downconversion_phase_inc.
REQ-012 SHALL have ports res_valid  out  1; res_ready  in  1; res_index  out  12; res_mag  out  MW; res_phase  out  PHW.
REQ-013 SHALL have ports busy  out  1  sweep active; done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, SETTLE, ACQ, EMIT, FINISH.
REQ-015 IDLE: start=1 with n_points>0 SHALL go to SETTLE next cycle with phase_inc=f_start, index=0, busy=1.
REQ-016 IDLE: start=1 with n_points=0 SHALL go to FINISH; no result emitted.
REQ-017 f_start, f_step, n_points, settle_samples SHALL be latched on the accepted start; later input changes are ignored until the next sweep.
REQ-018 SETTLE SHALL count ce_down pulses; on the settle_samples-th pulse it SHALL go to ACQ; settle_samples=0 SHALL enter ACQ the cycle after SETTLE entry.
REQ-019 ACQ SHALL sum rx_magnitude (MW+AVG_LOG2 bits, no overflow) on each ce_down and capture rx_phase on the last one.
REQ-020 After 2^AVG_LOG2 ce_down pulses, ACQ SHALL go to EMIT with res_mag = sum >> AVG_LOG2 (truncate), res_phase = last phase, res_index = point index.
REQ-021 EMIT SHALL hold res_valid=1 and all res_* stable until res_valid&&res_ready; ce_down during EMIT SHALL be ignored.
REQ-022 On handshake: if index = n_points-1, go to FINISH; else index+1, phase_inc += f_step (mod 2^PW, wrap silent), go to SETTLE next cycle.
REQ-023 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE with busy=0.
REQ-024 phase_inc SHALL hold its last value in IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 stop=1 in any non-IDLE state SHALL return to IDLE next cycle, clear res_valid, with no done pulse; stop has priority over a simultaneous handshake or ce_down.
REQ-027 stop and start in the same IDLE cycle: start SHALL win.

Reset
REQ-028 rst=0 at a clock edge SHALL force IDLE, phase_inc=0, busy=0, done=0, res_valid=0, res_index=0, res_mag=0, res_phase=0, accumulators and counters 0, regardless of the current state.
REQ-029 Reset asserted mid-sweep SHALL abandon the sweep; no done pulse follows reset release.

Configuration
REQ-030 Macro RX_SWEEP_PEAK_TRACK_EN defined SHALL add outputs peak_mag (MW) and peak_index (12), cleared at sweep start, updated on each result handshake when res_mag > peak_mag (strictly greater, first index wins ties), and valid when done pulses.
REQ-031 Without RX_SWEEP_PEAK_TRACK_EN the ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 f_start=1000, f_step=250, n_points=4, settle=3, res_ready=1, constant magnitude 0x1234 -> 4 results, index 0..3, res_mag=0x1234, phase_inc 1000,1250,1500,1750, single done pulse.
REQ-033 Magnitude ramp 0..15 in one ACQ window (AVG_LOG2=4) -> res_mag=7 (120>>4).
REQ-034 res_ready held low 20 cycles in EMIT, ce_down toggling -> res_* stable, no extra result, sweep resumes after ready.
REQ-035 f_start=0x7FFFF, f_step=2, n_points=2 -> second phase_inc=0x00001 (wrap).
REQ-036 stop during second point's SETTLE -> IDLE next cycle, busy=0, no done; rst=0 mid-ACQ -> all outputs zero.
REQ-037 n_points=0 start -> done one cycle after FINISH entry, no res_valid; with RX_SWEEP_PEAK_TRACK_EN, magnitudes 5,9,9,3 -> peak_mag=9, peak_index=1.
